// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame constants, baud_sel encodings, divisor table and receiver FSM states.
package uart_receiver_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BAUD_SEL_W = 3;
    localparam int unsigned DIV_W      = 16;

    typedef enum logic [BAUD_SEL_W-1:0] {
        BAUD_300    = 3'd0,
        BAUD_1200   = 3'd1,
        BAUD_4800   = 3'd2,
        BAUD_9600   = 3'd3,
        BAUD_19200  = 3'd4,
        BAUD_38400  = 3'd5,
        BAUD_57600  = 3'd6,
        BAUD_115200 = 3'd7
    } baud_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int unsigned baud_rate(input logic [BAUD_SEL_W-1:0] sel);
        case (baud_sel_e'(sel))
            BAUD_300:    return 300;
            BAUD_1200:   return 1200;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Clocks per oversample tick, rounded to nearest: round(clk_hz / (os * baud)).
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz,
                                                      input int unsigned os,
                                                      input logic [BAUD_SEL_W-1:0] sel);
        int unsigned step;
        step = os * baud_rate(sel);
        return DIV_W'((clk_hz + step / 2) / step);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clk tick every divisor clocks; restart re-phases the count.
module uart_baud_gen
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BAUD_SEL_W-1:0] baud_sel,
    input  logic                  restart,
    output logic                  tick
);

    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] cnt;

    assign div_c = baud_divisor(CLK_HZ, OVERSAMPLE, baud_sel);

    // A baud_sel change is only picked up when the counter reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= div_c - DIV_W'(1);
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= div_c - DIV_W'(1);
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive end: 8 data bits LSB first, even parity, one stop bit, 16x oversampled.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BAUD_SEL_W-1:0] baud_sel,
    input  logic                  Rx_EN,
    input  logic                  RxD,
    output logic [DATA_BITS-1:0]  Rx_DATA,
    output logic                  Rx_VALID,
    output logic                  Rx_PERROR,
    output logic                  Rx_FERROR,
    output logic                  Rx_BUSY
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rx_state_e              state;
    logic [1:0]             sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall_c;
    logic                   restart_c;
    logic                   tick;
    logic [TICK_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift;

    assign rx_s      = sync[1];
    assign fall_c    = rx_prev & ~rx_s;
    assign restart_c = (state == ST_IDLE) & Rx_EN & fall_c;

    // Two-flop synchroniser plus edge-detect history, all preset to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], RxD};
            rx_prev <= rx_s;
        end
    end

    uart_baud_gen #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .baud_sel (baud_sel),
        .restart  (restart_c),
        .tick     (tick)
    );

    // Frame FSM; each sample lands on the mid-bit tick, counted from the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_BUSY   <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state     <= ST_IDLE;
                Rx_BUSY   <= 1'b0;
                Rx_PERROR <= 1'b0;
                Rx_FERROR <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall_c) begin
                            state     <= ST_START;
                            tick_cnt  <= '0;
                            Rx_BUSY   <= 1'b1;
                            Rx_PERROR <= 1'b0;
                            Rx_FERROR <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            if (tick_cnt == MID_TICK) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                if (rx_s) begin
                                    state   <= ST_IDLE;
                                    Rx_BUSY <= 1'b0;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            if (tick_cnt == LAST_TICK) begin
                                tick_cnt <= '0;
                                shift    <= {rx_s, shift[DATA_BITS-1:1]};
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                                if (bit_cnt == LAST_BIT) begin
                                    state <= ST_PARITY;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (tick) begin
                            if (tick_cnt == LAST_TICK) begin
                                tick_cnt  <= '0;
                                Rx_PERROR <= rx_s ^ (^shift);
                                state     <= ST_STOP;
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            if (tick_cnt == LAST_TICK) begin
                                tick_cnt  <= '0;
                                Rx_FERROR <= ~rx_s;
                                Rx_BUSY   <= 1'b0;
                                state     <= ST_IDLE;
                                if (rx_s && !Rx_PERROR) begin
                                    Rx_VALID <= 1'b1;
                                    Rx_DATA  <= shift;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        Rx_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus random frames against a frame-level model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_sel;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    always #10 clk = ~clk;

    uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .baud_sel  (baud_sel),
        .Rx_EN     (Rx_EN),
        .RxD       (RxD),
        .Rx_DATA   (Rx_DATA),
        .Rx_VALID  (Rx_VALID),
        .Rx_PERROR (Rx_PERROR),
        .Rx_FERROR (Rx_FERROR),
        .Rx_BUSY   (Rx_BUSY)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Every cycle Rx_VALID is high records one byte, so queue length also checks pulse width.
    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) got_q.push_back(Rx_DATA);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Clocks per tick from the published table.
    function automatic int unsigned divisor(input logic [2:0] sel);
        case (sel)
            3'd0: return 10417;
            3'd1: return 2604;
            3'd2: return 651;
            3'd3: return 326;
            3'd4: return 163;
            3'd5: return 81;
            3'd6: return 54;
            default: return 27;
        endcase
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level expectation: errors from parity/stop rules, byte accepted only when clean.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        exp_pe = 1'(($countones(d) + int'(p)) % 2);
        exp_fe = ~s;
        if (!exp_pe && !exp_fe) begin
            exp_data = d;
            exp_q.push_back(d);
        end
    endtask

    // Drives the first nclk clocks of a frame; start bit first, bit time bc clocks.
    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s,
                               input int unsigned bc, input int unsigned nclk);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int unsigned n = 0; n < nclk; n++) begin
            @(negedge clk);
            RxD = bits[4'(n / bc)];
            if (n == 20) begin
                check_eq("start_busy", 32'(Rx_BUSY), 32'd1);
                check_eq("start_perr_clear", 32'(Rx_PERROR), 32'd0);
                check_eq("start_ferr_clear", 32'(Rx_FERROR), 32'd0);
            end
        end
    endtask

    task automatic post_frame(input string tag);
        check_eq({tag, " data"}, 32'(Rx_DATA), 32'(exp_data));
        check_eq({tag, " perr"}, 32'(Rx_PERROR), 32'(exp_pe));
        check_eq({tag, " ferr"}, 32'(Rx_FERROR), 32'(exp_fe));
        check_eq({tag, " busy"}, 32'(Rx_BUSY), 32'd0);
        check_eq({tag, " valid_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        int unsigned bc;
        bc = 16 * divisor(baud_sel);
        drive_frame(d, p, s, bc, 11 * bc);
        model_frame(d, p, s);
        post_frame($sformatf("frame %02h p%0d s%0d sel%0d", d, p, s, baud_sel));
        if (!s) begin
            RxD = 1'b1;
            idle(bc);
        end
    endtask

    // 100-clk glitch: busy should last about eight ticks, then drop with nothing else changing.
    task automatic false_start(input logic [2:0] sel);
        int unsigned div;
        int unsigned dur;
        logic        in_window;
        baud_sel = sel;
        div = divisor(sel);
        dur = 0;
        idle(4);
        for (int unsigned n = 0; n < 8 * div + 200; n++) begin
            @(negedge clk);
            if (n == 0) RxD = 1'b0;
            if (n == 100) RxD = 1'b1;
            if (Rx_BUSY === 1'b1) dur++;
        end
        in_window = (dur + 4 >= 8 * div) && (dur <= 8 * div + 6);
        check_eq($sformatf("false_start_busy sel=%0d busy_clks=%0d want~%0d", sel, dur, 8 * div),
                 32'(in_window), 32'd1);
    endtask

    initial begin
        int unsigned bc;
        logic [7:0]  d;
        logic        p;
        logic        s;
        int unsigned k;

        reset    = 1'b0;
        Rx_EN    = 1'b1;
        RxD      = 1'b1;
        baud_sel = 3'd7;
        exp_data = 8'h00;
        exp_pe   = 1'b0;
        exp_fe   = 1'b0;
        idle(3);
        check_eq("reset data", 32'(Rx_DATA), 32'd0);
        check_eq("reset valid", 32'(Rx_VALID), 32'd0);
        check_eq("reset perr", 32'(Rx_PERROR), 32'd0);
        check_eq("reset ferr", 32'(Rx_FERROR), 32'd0);
        check_eq("reset busy", 32'(Rx_BUSY), 32'd0);
        reset = 1'b1;
        idle(5);

        for (int sel = 7; sel >= 3; sel--) false_start(3'(sel));
        post_frame("after false starts");

        baud_sel = 3'd7;
        idle(5);
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);

        baud_sel = 3'd6;
        idle(5);
        send_frame(8'h55, 1'b0, 1'b1);

        baud_sel = 3'd7;
        idle(5);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            k = $urandom_range(0, 3);
            p = 1'($countones(d) % 2) ^ (k == 2);
            s = (k != 3);
            send_frame(d, p, s);
        end

        // Break: line low for 12 bit times, must not re-arm until it returns high.
        bc = 16 * divisor(baud_sel);
        drive_frame(8'h00, 1'b0, 1'b0, bc, 11 * bc);
        idle(bc);
        model_frame(8'h00, 1'b0, 1'b0);
        post_frame("break");
        Rx_EN = 1'b0;
        idle(2);
        check_eq("en_fall ferr_clear", 32'(Rx_FERROR), 32'd0);
        exp_fe = 1'b0;
        RxD = 1'b1;
        idle(bc);
        Rx_EN = 1'b1;
        idle(bc);

        // Enable dropped in the middle of D3.
        drive_frame(8'hC3, 1'b0, 1'b1, bc, 4 * bc + bc / 2);
        Rx_EN = 1'b0;
        idle(2);
        check_eq("en_abort busy", 32'(Rx_BUSY), 32'd0);
        check_eq("en_abort data_kept", 32'(Rx_DATA), 32'(exp_data));
        RxD = 1'b1;
        idle(bc);
        Rx_EN = 1'b1;
        idle(bc);
        post_frame("en_abort");

        // Async reset in the middle of D3.
        drive_frame(8'hC3, 1'b0, 1'b1, bc, 4 * bc + bc / 2);
        reset = 1'b0;
        #1;
        check_eq("mid_reset data", 32'(Rx_DATA), 32'd0);
        check_eq("mid_reset busy", 32'(Rx_BUSY), 32'd0);
        check_eq("mid_reset valid", 32'(Rx_VALID), 32'd0);
        exp_data = 8'h00;
        RxD = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(bc);
        post_frame("mid_reset");

        send_frame(8'h81, 1'b0, 1'b1);

        check_eq("scoreboard count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("scoreboard byte %0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
